// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB arbiter: operand widths, ROB sizing and the
// fixed source index assignment on the result-broadcast bus.
package cdb_arbiter_pkg;

    localparam int ROB_SIZE      = 16;
    localparam int ROB_POS_WIDTH = $clog2(ROB_SIZE);
    localparam int DATA_WIDTH    = 32;
    localparam int ADDR_WIDTH    = 32;
    localparam int NUM_CDB_SRC   = 3;
    localparam int CDB_SRC_W     = 2;

    typedef logic [ROB_POS_WIDTH-1:0] ROB_POS_TYPE;
    typedef logic [DATA_WIDTH-1:0]    DATA_TYPE;
    typedef logic [ADDR_WIDTH-1:0]    ADDR_TYPE;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [CDB_SRC_W-1:0] CDB_SRC_ALU   = 2'd0;
    localparam logic [CDB_SRC_W-1:0] CDB_SRC_LSB   = 2'd1;
    localparam logic [CDB_SRC_W-1:0] CDB_SRC_SPARE = 2'd2;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid source at or after ptr,
// wrapping modulo NUM_SRC. Produces a one-hot grant and its binary index.
module cdb_arbiter_rr_picker #(
    parameter int NUM_SRC = 3,
    parameter int PTR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any_grant
);

    always_comb begin
        int j;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        j         = 0;
        for (int off = 0; off < NUM_SRC; off++) begin
            j = (int'(ptr) + off) % NUM_SRC;
            if (!any_grant && valid[j]) begin
                any_grant = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Result-broadcast bus arbiter: round-robin grant among execution units,
// one registered broadcast per transfer, frozen by rdy, flushed by rollback.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC   = NUM_CDB_SRC,
    parameter int ROB_POS_W = ROB_POS_WIDTH,
    parameter int DATA_W    = DATA_WIDTH,
    parameter int ADDR_W    = ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,
    input  logic                          rollback,
    input  logic [NUM_SRC-1:0]            req_valid,
    output logic [NUM_SRC-1:0]            req_ready,
    input  logic [NUM_SRC*ROB_POS_W-1:0]  req_rob_pos,
    input  logic [NUM_SRC*DATA_W-1:0]     req_val,
    input  logic [NUM_SRC-1:0]            req_jump,
    input  logic [NUM_SRC*ADDR_W-1:0]     req_pc,
    output logic                          cdb_valid,
    output logic [ROB_POS_W-1:0]          cdb_rob_pos,
    output logic [DATA_W-1:0]             cdb_val,
    output logic                          cdb_jump,
    output logic [ADDR_W-1:0]             cdb_pc,
    output logic [CDB_SRC_W-1:0]          cdb_src
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [PTR_W-1:0]   rr_ptr;
    logic [NUM_SRC-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               any_grant;
    logic               arb_en;
    logic               xfer;

    logic [ROB_POS_W-1:0] sel_rob_pos;
    logic [DATA_W-1:0]    sel_val;
    logic                 sel_jump;
    logic [ADDR_W-1:0]    sel_pc;

    cdb_arbiter_rr_picker #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (PTR_W)
    ) u_picker (
        .valid     (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // Grants are suppressed whenever the registers below would not capture them.
    assign arb_en    = rdy && !rollback && !rst;
    assign req_ready = arb_en ? grant : '0;
    assign xfer      = arb_en && any_grant;

    always_comb begin
        sel_rob_pos = '0;
        sel_val     = '0;
        sel_jump    = 1'b0;
        sel_pc      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                sel_rob_pos = req_rob_pos[i*ROB_POS_W +: ROB_POS_W];
                sel_val     = req_val[i*DATA_W +: DATA_W];
                sel_jump    = req_jump[i];
                sel_pc      = req_pc[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid   <= FALSE;
            cdb_rob_pos <= '0;
            cdb_val     <= '0;
            cdb_jump    <= FALSE;
            cdb_pc      <= '0;
            cdb_src     <= '0;
            rr_ptr      <= '0;
        end else if (rollback) begin
            cdb_valid <= FALSE;
            rr_ptr    <= '0;
        end else if (rdy) begin
            cdb_valid <= xfer;
            if (xfer) begin
                cdb_rob_pos <= sel_rob_pos;
                cdb_val     <= sel_val;
                cdb_jump    <= sel_jump;
                cdb_pc      <= sel_pc;
                cdb_src     <= CDB_SRC_W'(grant_idx);
                rr_ptr      <= (grant_idx == PTR_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single grant, round-robin rotation,
// pointer-ordered contention, rdy stall and rollback flush.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int RW = 4;
    localparam int DW = 32;
    localparam int AW = 32;

    logic            clk;
    logic            rst;
    logic            rdy;
    logic            rollback;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*RW-1:0] req_rob_pos;
    logic [N*DW-1:0] req_val;
    logic [N-1:0]    req_jump;
    logic [N*AW-1:0] req_pc;
    logic            cdb_valid;
    logic [RW-1:0]   cdb_rob_pos;
    logic [DW-1:0]   cdb_val;
    logic            cdb_jump;
    logic [AW-1:0]   cdb_pc;
    logic [1:0]      cdb_src;

    int checks   = 0;
    int failures = 0;

    cdb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .rollback    (rollback),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rob_pos (req_rob_pos),
        .req_val     (req_val),
        .req_jump    (req_jump),
        .req_pc      (req_pc),
        .cdb_valid   (cdb_valid),
        .cdb_rob_pos (cdb_rob_pos),
        .cdb_val     (cdb_val),
        .cdb_jump    (cdb_jump),
        .cdb_pc      (cdb_pc),
        .cdb_src     (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] exp_grant;
        rst         = 1'b1;
        rdy         = 1'b1;
        rollback    = 1'b0;
        req_valid   = '1;
        req_rob_pos = '0;
        req_val     = '0;
        req_jump    = '0;
        req_pc      = '0;

        // Reset: outputs cleared, grants blocked even with requests present
        tick();
        tick();
        chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("rst_cdb_rob_pos", 64'(cdb_rob_pos), 64'd0);
        chk("rst_cdb_val", 64'(cdb_val), 64'd0);
        chk("rst_cdb_jump", 64'(cdb_jump), 64'd0);
        chk("rst_cdb_pc", 64'(cdb_pc), 64'd0);
        chk("rst_cdb_src", 64'(cdb_src), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rr_ptr", 64'(dut.rr_ptr), 64'd0);

        // Idle for 5 cycles
        rst       = 1'b0;
        req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("idle_cdb_valid", 64'(cdb_valid), 64'd0);
            chk("idle_req_ready", 64'(req_ready), 64'd0);
        end
        chk("idle_rr_ptr", 64'(dut.rr_ptr), 64'd0);

        // Single ALU request
        req_valid            = 3'b001;
        req_rob_pos[0 +: RW] = 4'd5;
        req_val[0 +: DW]     = 32'h1234;
        req_jump[0]          = 1'b1;
        req_pc[0 +: AW]      = 32'h80;
        #1;
        chk("alu_req_ready", 64'(req_ready), 64'b001);
        tick();
        req_valid = '0;
        chk("alu_cdb_valid", 64'(cdb_valid), 64'd1);
        chk("alu_cdb_rob_pos", 64'(cdb_rob_pos), 64'd5);
        chk("alu_cdb_val", 64'(cdb_val), 64'h1234);
        chk("alu_cdb_jump", 64'(cdb_jump), 64'd1);
        chk("alu_cdb_pc", 64'(cdb_pc), 64'h80);
        chk("alu_cdb_src", 64'(cdb_src), 64'(CDB_SRC_ALU));
        chk("alu_rr_ptr", 64'(dut.rr_ptr), 64'd1);
        tick();
        chk("alu_cdb_valid_drop", 64'(cdb_valid), 64'd0);
        chk("alu_payload_hold", 64'(cdb_rob_pos), 64'd5);

        // Bare rollback returns the pointer to 0
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        chk("rb_rr_ptr", 64'(dut.rr_ptr), 64'd0);

        // All three continuously valid: grants rotate 0,1,2,0,1,2
        req_rob_pos = {4'd3, 4'd2, 4'd1};
        req_val     = {32'hC, 32'hB, 32'hA};
        req_jump    = 3'b000;
        req_valid   = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp_grant = 3'b001 << (k % 3);
            #1;
            chk("rr_req_ready", 64'(req_ready), 64'(exp_grant));
            tick();
            chk("rr_cdb_valid", 64'(cdb_valid), 64'd1);
            chk("rr_cdb_src", 64'(k % 3), 64'(cdb_src) ^ 64'd0);
            chk("rr_cdb_rob_pos", 64'(cdb_rob_pos), 64'((k % 3) + 1));
        end
        chk("rr_ptr_after", 64'(dut.rr_ptr), 64'd0);

        // Move pointer to 2 via a lone LSB grant
        req_valid = 3'b010;
        tick();
        chk("ptr2_rr_ptr", 64'(dut.rr_ptr), 64'd2);

        // LSB and spare contend with rr_ptr=2: spare first, LSB waits
        req_rob_pos = {4'd9, 4'd3, 4'd0};
        req_val     = {32'h9999, 32'h3333, 32'h0};
        req_valid   = 3'b110;
        #1;
        chk("ct_first_ready", 64'(req_ready), 64'b100);
        tick();
        req_valid = 3'b010;
        chk("ct_spare_src", 64'(cdb_src), 64'(CDB_SRC_SPARE));
        chk("ct_spare_rob_pos", 64'(cdb_rob_pos), 64'd9);
        #1;
        chk("ct_second_ready", 64'(req_ready), 64'b010);
        tick();
        req_valid = '0;
        chk("ct_lsb_valid", 64'(cdb_valid), 64'd1);
        chk("ct_lsb_src", 64'(cdb_src), 64'(CDB_SRC_LSB));
        chk("ct_lsb_rob_pos", 64'(cdb_rob_pos), 64'd3);
        chk("ct_lsb_val", 64'(cdb_val), 64'h3333);
        tick();
        chk("ct_cdb_valid_drop", 64'(cdb_valid), 64'd0);

        // ALU grant then rdy low for 3 cycles: broadcast frozen, no grants
        req_rob_pos[0 +: RW] = 4'd7;
        req_val[0 +: DW]     = 32'h77;
        req_valid            = 3'b001;
        #1;
        chk("st_grant_ready", 64'(req_ready), 64'b001);
        tick();
        rdy       = 1'b0;
        req_valid = 3'b010;
        #1;
        chk("st_ready_blocked", 64'(req_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("st_cdb_valid_hold", 64'(cdb_valid), 64'd1);
            chk("st_rob_pos_hold", 64'(cdb_rob_pos), 64'd7);
            chk("st_ready_zero", 64'(req_ready), 64'd0);
        end
        rdy       = 1'b1;
        req_valid = '0;
        #1;
        chk("st_release_valid", 64'(cdb_valid), 64'd1);
        tick();
        chk("st_after_valid", 64'(cdb_valid), 64'd0);
        chk("st_rr_ptr", 64'(dut.rr_ptr), 64'd1);

        // ALU granted in N, rollback in N+1 with LSB valid
        req_rob_pos[0 +: RW] = 4'd4;
        req_valid            = 3'b001;
        #1;
        chk("fl_grant_ready", 64'(req_ready), 64'b001);
        tick();
        rollback  = 1'b1;
        req_valid = 3'b010;
        #1;
        chk("fl_cdb_valid_n1", 64'(cdb_valid), 64'd1);
        chk("fl_ready_blocked", 64'(req_ready), 64'd0);
        tick();
        rollback  = 1'b0;
        req_valid = '0;
        chk("fl_cdb_valid_n2", 64'(cdb_valid), 64'd0);
        chk("fl_rr_ptr", 64'(dut.rr_ptr), 64'd0);
        tick();
        chk("fl_no_late_bcast", 64'(cdb_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single result-broadcast bus (CDB) among several execution units: ALU, LSB load port, and a spare slot for a future MUL/DIV unit.
- Each cycle, grants at most one valid requester by round-robin and registers its result onto the CDB.
- The CDB feeds the ROB writeback port (rob_pos, val, jump, dest pc) and the RS/LSB operand wake-up logic.
- Flushes on rollback.

Parameters:
- NUM_SRC, 3, number of requesting units; index 0 = ALU, 1 = LSB, 2 = spare.
- ROB_POS_W, 4, ROB index width (ROB_SIZE = 16).
- DATA_W, 32, result value width.
- ADDR_W, 32, branch destination pc width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global ready; low = freeze.
- rollback  in  1  mispredict flush from ROB.
- req_valid  in  NUM_SRC  per-source result valid.
- req_ready  out  NUM_SRC  per-source grant (combinational).
- req_rob_pos  in  NUM_SRC*ROB_POS_W  per-source ROB tag, source i at bits [i*ROB_POS_W +: ROB_POS_W].
- req_val  in  NUM_SRC*DATA_W  per-source result value.
- req_jump  in  NUM_SRC  per-source branch-taken flag.
- req_pc  in  NUM_SRC*ADDR_W  per-source branch/jalr target.
- cdb_valid  out  1  broadcast valid.
- cdb_rob_pos  out  ROB_POS_W  broadcast ROB tag.
- cdb_val  out  DATA_W  broadcast value.
- cdb_jump  out  1  broadcast taken flag.
- cdb_pc  out  ADDR_W  broadcast target pc.
- cdb_src  out  2  index of the granted source (debug/verification).

Behaviour:
- Reset (rst high at posedge):
  - cdb_valid = 0; cdb_rob_pos, cdb_val, cdb_jump, cdb_pc, cdb_src = 0.
  - rr_ptr = 0.
  - req_ready = 0 while rst is high.
- Handshake:
  - A transfer on source i occurs when req_valid[i] && req_ready[i] at a posedge.
  - Requesters hold valid and payload stable until granted.
  - req_ready is never asserted unless req_valid is.
- Arbitration (combinational, when rdy && !rollback && !rst):
  - Scan i = rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
  - The first source with req_valid set gets req_ready.
  - At most one req_ready is high (one-hot or zero).
- Registered output, latency 1:
  - On a grant, the next cycle shows cdb_valid = 1 with the granted source's payload and cdb_src = i.
  - With no grant, cdb_valid = 0; the payload registers hold their old values.
  - cdb_valid lasts exactly one cycle per transfer.
- Pointer update: on a grant to i, rr_ptr <= (i+1) mod NUM_SRC. With no grant, rr_ptr is unchanged.
  - Wrap: a grant to NUM_SRC-1 sets rr_ptr to 0.
- Fairness: a continuously valid source is granted within NUM_SRC cycles.
- rdy low:
  - All req_ready = 0.
  - All registers hold, including cdb_valid, so a pending broadcast is consumed exactly once after rdy returns. The ROB also freezes while rdy is low.
- rollback high at posedge (priority over rdy; rst has priority over rollback):
  - All req_ready = 0 that cycle.
  - cdb_valid <= 0 and rr_ptr <= 0.
  - A broadcast from the cycle before rollback is dropped.
- Simultaneous requests: only one is granted; the losers retry the next cycle with unchanged payload.
- rob_pos collisions between sources are not checked; the issue logic guarantees unique tags.

Decomposition:
- Shared definition file: ROB_POS_TYPE, DATA_TYPE, ADDR_TYPE, ROB_SIZE, TRUE/FALSE, plus a new CDB_SRC_ALU/LSB/SPARE index constant set.
- Sub-module rr_picker: purely combinational.
  - Inputs: NUM_SRC-wide valid vector and rr_ptr.
  - Outputs: one-hot grant plus binary index.
  - Reusable for a future LSB memory-port arbiter.
- cdb_arbiter owns rr_ptr, the output registers and the flush/stall gating.

Test Plan:
- Reset then idle, no requests for 5 cycles → cdb_valid stays 0, req_ready = 000, rr_ptr = 0.
- Single ALU request (valid[0], rob_pos=5, val=0x1234, jump=1, pc=0x80) → req_ready=001 the same cycle; next cycle cdb_valid=1, cdb_rob_pos=5, cdb_val=0x1234, cdb_jump=1, cdb_pc=0x80, cdb_src=0; the following cycle cdb_valid=0.
- All three valid continuously from rr_ptr=0 → grant sequence 0,1,2,0,1,2; every source is granted within 3 cycles.
- LSB (rob_pos=3) and spare (rob_pos=9) valid with rr_ptr=2 → spare granted first, then LSB; LSB payload stays stable and is broadcast 2 cycles after the first grant.
- Grant to ALU (rob_pos=7), then rdy low for 3 cycles → cdb_valid=1 with rob_pos=7 held throughout, req_ready=000; after rdy rises, exactly one more cycle of cdb_valid.
- ALU granted in cycle N, rollback asserted in cycle N+1 with LSB valid → cdb_valid=0 in N+2, LSB not granted in N+1, rr_ptr=0 afterwards.
